elastic_pipeline: RTL
=====================

Name: elastic_pipeline

Overview:
Parametrised valid/ready register pipeline. It replaces single-stage handshake registers on the UART-to-ALU and ALU-to-UART datapaths. It has configurable depth, an optional input skid buffer that makes ready_o a pure flop output, bubble collapsing, a synchronous flush and an occupancy count. Sustains one transfer per cycle at any depth.

Parameters:
width_p, 10, payload width in bits (>=1)
depth_p, 2, number of pipeline register stages (>=1)
skid_p, 1, 1 = input skid register, ready_o registered; 0 = ready_o combinational from downstream

Ports:
clk_i  input  1  clock, all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
flush_i  input  1  synchronous clear of all held entries
data_i  input  width_p  upstream payload
valid_i  input  1  upstream valid
ready_o  output  1  upstream may transfer when valid_i & ready_o
valid_o  output  1  downstream valid
data_o  output  width_p  downstream payload, driven from last stage
ready_i  input  1  downstream ready
count_o  output  $clog2(depth_p+skid_p+1)  entries currently held (stages + skid)

Behaviour:
- Interface is fixed: one clock, clk_i; reset_i is synchronous and active-high.
- Stages s0..s(depth_p-1), each a valid bit plus a width_p data register. s(depth_p-1) drives valid_o and data_o.
- Stage readiness (bubble collapsing): rdy(k) = rdy(k+1) | ~valid(k). For the last stage, rdy = ready_i | ~valid_o. A stage loads when rdy(k) is 1. Its valid becomes the upstream offer, and its data loads only when the offer is valid.
- Handshakes:
  - Input transfer = valid_i & ready_o.
  - Output transfer = valid_o & ready_i.
  - data_o holds stable while valid_o=1 and ready_i=0.
  - Once valid_o is asserted, it never deasserts without an output transfer, except on reset or flush.
- skid_p=0:
  - ready_o = rdy(0), combinational.
  - Capacity is depth_p.
- skid_p=1: one skid entry sits in front of s0, and ready_o = ~skid_valid (flop).
  - If skid is empty and rdy(0)=1, input goes directly to s0.
  - If skid is empty, rdy(0)=0 and an input transfer occurs, the data is captured in skid.
  - If skid is full and rdy(0)=1, skid moves to s0 and skid empties. ready_o is low that cycle, so there is no input transfer.
  - Capacity is depth_p+1.
- Latency: an accepted input appears on valid_o exactly depth_p cycles later when the pipe is unstalled. Each cycle spent in skid adds one cycle.
- Throughput: with ready_i held 1, the block accepts and emits one item per cycle with no bubbles, for any depth_p and skid_p.
- Ordering: strictly FIFO. No loss or duplication.
- count_o:
  - Sum of all stage valids plus skid_valid, registered-consistent with state.
  - Ranges 0..depth_p+skid_p, with no wrap.
  - Increments on input-only, decrements on output-only, unchanged on simultaneous in and out.
- flush_i=1:
  - At the next edge, all valid bits and skid_valid clear, and count_o becomes 0.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts as delivered downstream.
  - Data registers are unchanged.
- reset_i=1: all valids, skid_valid and data registers clear to 0 at the edge. Reset has priority over flush_i and all handshakes.
- Values after the reset edge:
  - valid_o=0, data_o=0, count_o=0.
  - ready_o=1 (skid_p=1), or ready_o=1 via ~valid (skid_p=0).
- Reset mid-stream: all in-flight items are dropped. The first post-reset input gets full depth_p latency.
- No combinational path from valid_i to ready_o or valid_o. When skid_p=1, there is no combinational path from ready_i to ready_o.

Test Plan:
- Stream (depth_p=3, skid_p=1): ready_i=1, send 0x001..0x00A back-to-back. valid_o first rises 3 cycles after the first accept. 0x001..0x00A emerge on consecutive cycles. count_o steady at 3.
- Backpressure fill (depth_p=2, skid_p=1): ready_i=0, offer 0x3A1,0x3A2,0x3A3,0x3A4. Exactly three are accepted, and ready_o drops the cycle after the third. count_o=3. data_o=0x3A1 stays stable. Raising ready_i drains 0x3A1,0x3A2,0x3A3 in order, then 0x3A4 is accepted.
- Bubble collapse (depth_p=4): inject 0x055, wait 1 cycle idle, inject 0x0AA with ready_i=0. Both end in the last two stages. count_o=2. ready_o stays 1.
- Alternating ready_i (1010...) during a continuous offer: no item is lost or duplicated. count_o never exceeds depth_p+skid_p, and the scoreboard matches the input order.
- Flush: fill to count_o=3, assert flush_i with valid_i=1 and data 0x1FF. The next cycle shows valid_o=0 and count_o=0, and 0x1FF never appears.
- Reset mid-operation (skid_p=0): with 2 items in flight, pulse reset_i. valid_o=0, data_o=0, count_o=0, ready_o=1. The next accepted item appears after depth_p cycles.

Source files
------------

// File: rtl/elastic_pipeline.sv
// Elastic valid/ready pipeline: depth_p bubble-collapsing stages with an optional skid entry in front.
// Latency depth_p cycles unstalled (+1 per cycle held in skid); full rate with ready_i high; ready_o is a flop when skid_p=1.
module elastic_pipeline #(
   parameter int width_p = 10,
   parameter int depth_p = 2,
   parameter int skid_p  = 1
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   flush_i,
   input  logic [width_p-1:0]                     data_i,
   input  logic                                   valid_i,
   output logic                                   ready_o,
   output logic                                   valid_o,
   output logic [width_p-1:0]                     data_o,
   input  logic                                   ready_i,
   output logic [$clog2(depth_p+skid_p+1)-1:0]    count_o
);
   localparam int cnt_w_lp = $clog2(depth_p+skid_p+1);

   logic [depth_p-1:0]  r_vld;
   logic [width_p-1:0]  r_dat [depth_p];
   logic                r_skid_vld;
   logic [width_p-1:0]  r_skid_dat;

   logic [depth_p-1:0]  w_rdy;
   logic [depth_p-1:0]  w_in_vld;
   logic [width_p-1:0]  w_in_dat [depth_p];
   logic                w_off_vld;
   logic [width_p-1:0]  w_off_dat;
   logic [cnt_w_lp-1:0] w_cnt;

   // A stage can load if it is empty or anything downstream of it can move.
   always_comb begin
      logic v_acc;
      v_acc = ready_i;
      w_rdy = '0;
      for (int k = depth_p-1; k >= 0; k--) begin
         v_acc    = v_acc | ~r_vld[k];
         w_rdy[k] = v_acc;
      end
   end

   assign w_off_vld = r_skid_vld | valid_i;
   assign w_off_dat = r_skid_vld ? r_skid_dat : data_i;

   always_comb begin
      w_in_vld[0] = w_off_vld;
      w_in_dat[0] = w_off_dat;
      for (int k = 1; k < depth_p; k++) begin
         w_in_vld[k] = r_vld[k-1];
         w_in_dat[k] = r_dat[k-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_vld <= '0;
         for (int k = 0; k < depth_p; k++) begin
            r_dat[k] <= '0;
         end
      end else if (flush_i) begin
         r_vld <= '0;
      end else begin
         for (int k = 0; k < depth_p; k++) begin
            if (w_rdy[k]) begin
               r_vld[k] <= w_in_vld[k];
               if (w_in_vld[k]) begin
                  r_dat[k] <= w_in_dat[k];
               end
            end
         end
      end
   end

   generate
      if (skid_p != 0) begin : g_skid
         // Skid catches the one transfer already promised by the registered ready_o.
         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               r_skid_vld <= 1'b0;
               r_skid_dat <= '0;
            end else if (flush_i) begin
               r_skid_vld <= 1'b0;
            end else if (r_skid_vld) begin
               if (w_rdy[0]) begin
                  r_skid_vld <= 1'b0;
               end
            end else if (valid_i && !w_rdy[0]) begin
               r_skid_vld <= 1'b1;
               r_skid_dat <= data_i;
            end
         end
         assign ready_o = ~r_skid_vld;
      end else begin : g_no_skid
         assign r_skid_vld = 1'b0;
         assign r_skid_dat = '0;
         assign ready_o    = w_rdy[0];
      end
   endgenerate

   always_comb begin
      w_cnt = cnt_w_lp'(r_skid_vld);
      for (int k = 0; k < depth_p; k++) begin
         w_cnt = w_cnt + cnt_w_lp'(r_vld[k]);
      end
   end

   assign count_o = w_cnt;
   assign valid_o = r_vld[depth_p-1];
   assign data_o  = r_dat[depth_p-1];

endmodule
